rr_decode_arbiter: RTL
======================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 4-way resource select among 4 requesters.
- Picks a winner and holds the grant while that requester keeps its request high.
- Drives the winner's 2-bit address through a 2-to-4 decoder with enable to produce a one-hot grant bus.
- Sits in front of the existing decoder datapath and sequences which output line is active in each cycle.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner when another requester is waiting (used only with the optional feature). Legal range 1..255.
- HOLD_W, 8, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] is held high by requester i for as long as it wants the resource.
- grant  output  4  one-hot grant, registered; all zeros when there is no owner.
- grant_addr  output  2  binary index of the owner; 0 when idle.
- grant_valid  output  1  high exactly when the grant bus is non-zero.
- last_owner  output  2  most recent owner, which sets round-robin priority.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including an active grant):
  - state=IDLE, grant=0000, grant_addr=0, grant_valid=0, last_owner=3, hold counter=0.
  - last_owner=3 makes req[0] highest priority after reset.
- States: IDLE, GRANT.
- IDLE:
  - If req is non-zero at a rising edge, pick the first set bit searching last_owner+1, last_owner+2, … modulo 4 (wraps 3→0).
  - On that same edge: grant_addr=winner, grant_valid=1, grant=decode(winner), go to GRANT.
  - Latency: request sampled high at edge N gives grant visible after edge N.
  - If req=0000, stay in IDLE with outputs zero.
- GRANT:
  - While req[grant_addr]=1, hold grant, grant_addr and grant_valid unchanged; other requests are ignored.
  - When req[grant_addr]=0 at an edge: last_owner=grant_addr, grant=0000, grant_valid=0, grant_addr=0, go to IDLE.
- Turnaround: there is always at least one idle cycle between two owners. No back-to-back handoff.
- Owner drops its request in the same cycle another requester raises: the release is processed first. The new requester is arbitrated on the following edge.
- Requests from non-owners arriving or leaving during GRANT have no effect on state.
- Invariants:
  - grant is always zero or one-hot.
  - grant==decode(grant_addr) when grant_valid=1.
  - grant_valid==(state==GRANT).

Optional Feature:
- Macro: RR_DECODE_ARBITER_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each cycle in GRANT, saturating at MAX_HOLD.
  - If counter==MAX_HOLD and any other req bit is high, the grant is forcibly released at that edge: same actions as a voluntary release, with last_owner=owner, so the old owner has lowest priority next.
  - If no other requester is waiting, the counter saturates and the grant continues.
- Undefined:
  - No counter logic exists; a grant lasts until voluntary release.
  - The MAX_HOLD and HOLD_W parameters are accepted but unused.

Decomposition:
- Shared constants (state encodings IDLE=0 and GRANT=1, reset value of last_owner) go in an include file used by both RTL and bench.
- One sub-module, decoder_2to4_en (inputs addr0, addr1, enable; outputs out0..out3), instantiated with enable=grant_valid_next.
- The grant register captures the decoder output.

Test Plan:
- Reset mid-grant: owner 2 active, assert reset for 1 cycle → grant=0000, grant_valid=0, last_owner=3; next request 1111 grants 0001.
- Single requester: req=0100 → after one edge grant=0100, grant_addr=2; drop req → next edge grant=0000; re-raise → granted again.
- Round robin: req=1111 held, each owner drops for one cycle and re-raises → grant sequence 0001,0010,0100,1000,0001 with one zero cycle between each.
- Wrap-around: last_owner=3, req=1001 → grant 0001; after release with req still 1001 → grant 1000.
- Simultaneous release and new request: owner 0 drops while req[1] rises the same cycle → one cycle grant=0000, then 0010.
- With RR_DECODE_ARBITER_TIMEOUT_EN and MAX_HOLD=4: req=0011 held constantly → owner 0 holds for exactly 4 cycles counted from the grant, then one zero cycle, then grant=0010. With req=0001 only → grant never drops.

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
// The state encoding and the reset owner value are also imported by the bench.
package rr_decode_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Reset owner of 3 makes req[0] the highest priority after reset.
    localparam logic [1:0] LAST_OWNER_RST = 2'd3;

    // First set request searching last+1, last+2, ... modulo 4.
    // The loop runs from lowest to highest priority so the last hit wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_decoder_2to4_en.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2to4_en (
    input  logic addr0,
    input  logic addr1,
    input  logic enable,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3
);
    assign out0 = enable & ~addr1 & ~addr0;
    assign out1 = enable & ~addr1 &  addr0;
    assign out2 = enable &  addr1 & ~addr0;
    assign out3 = enable &  addr1 &  addr0;
endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter holding a one-hot grant while the owner keeps requesting.
// Define RR_DECODE_ARBITER_TIMEOUT_EN to force release after MAX_HOLD cycles when others wait.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_addr,
    output logic       grant_valid,
    output logic [1:0] last_owner
);
    state_t     r_state, w_state_next;
    logic [3:0] r_grant;
    logic [1:0] r_grant_addr, r_last_owner;
    logic       w_timeout, w_release, w_valid_next;
    logic [1:0] w_addr_next;
    logic [3:0] w_dec;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_param
            $error("rr_decode_arbiter: illegal MAX_HOLD/HOLD_W");
        end
    endgenerate

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    logic [HOLD_W-1:0] r_hold, w_hold_inc;

    // w_hold_inc is the number of grant cycles completed at this edge.
    assign w_hold_inc = (r_hold == HOLD_MAX) ? HOLD_MAX : r_hold + HOLD_W'(1);
    assign w_timeout  = (r_state == ST_GRANT) && (w_hold_inc == HOLD_MAX) && |(req & ~r_grant);

    always_ff @(posedge clk) begin
        if (reset || r_state == ST_IDLE) r_hold <= '0;
        else                             r_hold <= w_hold_inc;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = (r_state == ST_GRANT) && (!req[r_grant_addr] || w_timeout);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (|req)     w_state_next = ST_GRANT;
            ST_GRANT: if (w_release) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Release always passes through IDLE, so a new owner is never picked in GRANT.
    always_comb begin
        w_valid_next = (w_state_next == ST_GRANT);
        w_addr_next  = 2'd0;
        if (r_state == ST_IDLE) begin
            if (|req) w_addr_next = rr_pick(req, r_last_owner);
        end else if (!w_release) begin
            w_addr_next = r_grant_addr;
        end
    end

    decoder_2to4_en u_dec (
        .addr0  (w_addr_next[0]),
        .addr1  (w_addr_next[1]),
        .enable (w_valid_next),
        .out0   (w_dec[0]),
        .out1   (w_dec[1]),
        .out2   (w_dec[2]),
        .out3   (w_dec[3])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= 4'b0000;
            r_grant_addr <= 2'd0;
            r_last_owner <= LAST_OWNER_RST;
        end else begin
            r_grant      <= w_dec;
            r_grant_addr <= w_addr_next;
            if (w_release) r_last_owner <= r_grant_addr;
        end
    end

    assign grant       = r_grant;
    assign grant_addr  = r_grant_addr;
    assign grant_valid = (r_state == ST_GRANT);
    assign last_owner  = r_last_owner;

endmodule
